data_mem_arbiter: RTL and testbench

- Shares the single-port data memory between the processor core and one external burst requester (debug/DMA port).
- The core normally owns memory through a zero-latency combinational pass-through.
- The external port gets fixed-length word bursts, granted when the core is idle or after a bounded starvation interval.
- The core is frozen via core_stall, which is ORed into the program counter halt path.

---
 rtl/risc_mem_pkg.sv | 25 ++
 rtl/burst_addr_gen.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_mem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding,
// default widths and the word stride used for burst addressing.
package risc_mem_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LEN_W        = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  // Byte distance between consecutive burst beats.
  localparam int WORD_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // core owns memory through the pass-through
    GRANT = 2'd1,  // one-cycle handshake, burst fields latched
    BURST = 2'd2,  // one external beat per cycle
    DONE  = 2'd3   // one-cycle completion pulse
  } arb_state_t;

  // Bits needed to count from 0 up to and including limit.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: latches the granted burst fields, counts
// beats and produces the wrapped word address of the current beat.
module burst_addr_gen
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              start_we,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              last_beat,
  output logic              burst_we
);

  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat_cnt;
  logic              we;

  // Capture burst fields on grant, then step the beat counter each beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_addr <= '0;
      len       <= '0;
      we        <= 1'b0;
      beat_cnt  <= '0;
    end else if (load) begin
      base_addr <= start_addr;
      len       <= start_len;
      we        <= start_we;
      beat_cnt  <= '0;
    end else if (advance) begin
      beat_cnt  <= beat_cnt + LEN_W'(1);
    end
  end

  // Address arithmetic is ADDR_W wide so it wraps naturally past the top;
  // the low two bits of a misaligned base pass through untouched.
  assign beat_addr = base_addr + ADDR_W'(beat_cnt) * ADDR_W'(WORD_STRIDE);
  assign last_beat = (beat_cnt == len);
  assign burst_we  = we;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: the core owns memory through a combinational
// pass-through; an external requester gets fixed-length word bursts when
// the core is idle or after a bounded starvation interval.
module data_mem_arbiter
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]  ext_len,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_wready,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              ext_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = starve_cnt_width(STARVE_LIMIT);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic                core_active;
  logic                starve_hit;
  logic                addr_load;
  logic                addr_advance;
  logic                burst_we;
  logic                last_beat;
  logic [ADDR_W-1:0]   burst_addr;

  assign core_active = core_read | core_write;
  assign starve_hit  = (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));
  // Core load data always comes straight from memory; while the core is
  // stalled the value is simply ignored.
  assign core_rdata  = mem_rdata;

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (addr_load),
    .advance    (addr_advance),
    .start_addr (ext_addr),
    .start_len  (ext_len),
    .start_we   (ext_we),
    .beat_addr  (burst_addr),
    .last_beat  (last_beat),
    .burst_we   (burst_we)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counts consecutive cycles the requester waits behind an active core;
  // cleared after every burst so the core gets a turn between bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (ext_req && core_active) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end else if (state == DONE) begin
      starve_cnt <= '0;
    end
  end

  // Read beats are returned one cycle after the memory access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= (state == BURST) && !burst_we;
      if ((state == BURST) && !burst_we) begin
        ext_rdata <= mem_rdata;
      end
    end
  end

  // Next-state logic and memory-port muxing.
  always_comb begin
    state_next   = state;
    ext_gnt      = 1'b0;
    ext_wready   = 1'b0;
    ext_done     = 1'b0;
    core_stall   = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_load    = 1'b0;
    addr_advance = 1'b0;
    case (state)
      IDLE: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_read  = core_read;
        mem_write = core_write;
        if (ext_req && (!core_active || starve_hit)) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        ext_gnt    = 1'b1;
        core_stall = core_active;
        addr_load  = 1'b1;
        state_next = BURST;
      end
      BURST: begin
        core_stall = core_active;
        mem_addr   = burst_addr;
        if (burst_we) begin
          mem_write  = 1'b1;
          mem_wdata  = ext_wdata;
          ext_wready = 1'b1;
        end else begin
          mem_read   = 1'b1;
        end
        if (last_beat) begin
          state_next = DONE;
        end else begin
          addr_advance = 1'b1;
        end
      end
      DONE: begin
        ext_done   = 1'b1;
        core_stall = core_active;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus
// randomized bursts, checked against a word-array model of memory.
module tb_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_read, core_write;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [LW-1:0] ext_len;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_wready, ext_rvalid, ext_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;

  // Backing store standing in for data_mem (combinational read).
  logic [DW-1:0] dmem [0:255] = '{default: 32'h0};
  // Reference picture of memory, updated from the burst/store rules.
  logic [DW-1:0] ref_mem [0:255] = '{default: 32'h0};
  logic [DW-1:0] wbeat [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_wready(ext_wready),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_done(ext_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Full burst transaction: request, grant latency, every beat, done, and
  // the first idle cycle afterwards. ext_req stays high when keep_req is set.
  task automatic run_burst(input logic we, input logic [31:0] addr, input logic [3:0] len,
                           input logic core_busy, input int exp_wait, input logic keep_req,
                           input string tag);
    int gnt_at;
    int nb;
    logic [31:0] a;
    logic [31:0] ra;
    nb = int'(len) + 1;
    gnt_at = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_len = len; ext_wdata = $urandom;
      core_read = core_busy; core_write = 1'b0; core_addr = 32'h200;
      #1;
      if (ext_gnt === 1'b1) begin
        gnt_at = c;
        break;
      end
      n_cmp++;
      if (core_stall !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_stall [%s] cycle %0d got %b expected 0", tag, c, core_stall);
      end
    end
    n_cmp++;
    if (gnt_at != exp_wait) begin
      n_bad++;
      $display("FAIL gnt_latency [%s] got %0d expected %0d", tag, gnt_at, exp_wait);
    end
    if (gnt_at < 0) return;
    n_cmp++;
    if (core_stall !== core_busy || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL grant_cycle [%s] stall=%b rd=%b wr=%b expected stall=%b rd=0 wr=0",
               tag, core_stall, mem_read, mem_write, core_busy);
    end
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      ext_req = keep_req; ext_addr = $urandom; ext_we = ~we; ext_len = LW'($urandom);
      ext_wdata = wbeat[i];
      #1;
      a = addr + 32'(4 * i);
      n_cmp++;
      if (mem_addr !== a) begin
        n_bad++;
        $display("FAIL beat_addr [%s] beat %0d got %h expected %h", tag, i, mem_addr, a);
      end
      n_cmp++;
      if (mem_write !== we || mem_read !== !we || ext_wready !== we) begin
        n_bad++;
        $display("FAIL beat_ctrl [%s] beat %0d wr=%b rd=%b wready=%b expected we=%b",
                 tag, i, mem_write, mem_read, ext_wready, we);
      end
      n_cmp++;
      if (core_stall !== core_busy || ext_done !== 1'b0 || ext_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL beat_flags [%s] beat %0d stall=%b done=%b gnt=%b expected stall=%b done=0 gnt=0",
                 tag, i, core_stall, ext_done, ext_gnt, core_busy);
      end
      if (we) begin
        n_cmp++;
        if (mem_wdata !== wbeat[i]) begin
          n_bad++;
          $display("FAIL beat_wdata [%s] beat %0d got %h expected %h", tag, i, mem_wdata, wbeat[i]);
        end
        ref_mem[a[9:2]] = wbeat[i];
      end else begin
        n_cmp++;
        if (ext_rvalid !== (i > 0)) begin
          n_bad++;
          $display("FAIL rvalid [%s] beat %0d got %b expected %b", tag, i, ext_rvalid, (i > 0));
        end
        if (i > 0) begin
          ra = addr + 32'(4 * (i - 1));
          n_cmp++;
          if (ext_rdata !== ref_mem[ra[9:2]]) begin
            n_bad++;
            $display("FAIL rdata [%s] beat %0d got %h expected %h", tag, i - 1, ext_rdata, ref_mem[ra[9:2]]);
          end
        end
      end
    end
    @(negedge clk);
    ext_req = keep_req;
    #1;
    n_cmp++;
    if (ext_done !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || core_stall !== core_busy) begin
      n_bad++;
      $display("FAIL done_cycle [%s] done=%b rd=%b wr=%b stall=%b expected 1/0/0/%b",
               tag, ext_done, mem_read, mem_write, core_stall, core_busy);
    end
    n_cmp++;
    if (ext_rvalid !== !we) begin
      n_bad++;
      $display("FAIL done_rvalid [%s] got %b expected %b", tag, ext_rvalid, !we);
    end
    if (!we) begin
      ra = addr + 32'(4 * int'(len));
      n_cmp++;
      if (ext_rdata !== ref_mem[ra[9:2]]) begin
        n_bad++;
        $display("FAIL last_rdata [%s] got %h expected %h", tag, ext_rdata, ref_mem[ra[9:2]]);
      end
    end
    @(negedge clk);
    ext_req = keep_req;
    #1;
    n_cmp++;
    if (ext_done !== 1'b0 || core_stall !== 1'b0 || mem_read !== core_busy || ext_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_done [%s] done=%b stall=%b rd=%b rvalid=%b expected 0/0/%b/0",
               tag, ext_done, core_stall, mem_read, ext_rvalid, core_busy);
    end
    $display("burst %s we=%0b addr=%h len=%0d core_busy=%0b gnt_wait=%0d", tag, we, addr, len, core_busy, gnt_at);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    core_read = 1'b0; core_write = 1'b0; ext_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    core_read = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_len = '0; ext_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ext_gnt, ext_wready, ext_rvalid, ext_done, core_stall} !== 5'b0 || ext_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got gnt=%b wready=%b rvalid=%b done=%b stall=%b rdata=%h expected all 0",
               ext_gnt, ext_wready, ext_rvalid, ext_done, core_stall, ext_rdata);
    end
    @(negedge clk);
    ext_req = 1'b0;
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_core_only();
    @(negedge clk);
    core_write = 1'b1; core_read = 1'b0; core_addr = 32'h40; core_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF || core_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL core_store wr=%b addr=%h wdata=%h stall=%b expected 1/00000040/deadbeef/0",
               mem_write, mem_addr, mem_wdata, core_stall);
    end
    ref_mem[16] = 32'hDEADBEEF;
    @(negedge clk);
    core_write = 1'b0; core_read = 1'b1;
    #1;
    n_cmp++;
    if (core_rdata !== 32'hDEADBEEF || mem_read !== 1'b1 || core_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL core_load rdata=%h rd=%b stall=%b expected deadbeef/1/0", core_rdata, mem_read, core_stall);
    end
    $display("core store+load 0x40");
    idle_inputs();
  endtask

  task automatic test_write_then_core_read();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) wbeat[i] = 32'(i + 1);
    run_burst(1'b1, 32'h100, 4'd3, 1'b0, 1, 1'b0, "wr100");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_read = 1'b1; core_addr = 32'h100 + 32'(4 * i);
      #1;
      exp = 32'(i + 1);
      n_cmp++;
      if (core_rdata !== exp || core_stall !== 1'b0) begin
        n_bad++;
        $display("FAIL core_readback addr=%h got %h stall=%b expected %h stall=0", core_addr, core_rdata, core_stall, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_burst();
    run_burst(1'b0, 32'h100, 4'd3, 1'b1, SL, 1'b0, "rd100_busy");
    idle_inputs();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 2; i++) wbeat[i] = $urandom;
    run_burst(1'b1, 32'h300, 4'd1, 1'b1, SL, 1'b1, "starve_1");
    // Request still held: the core got its access in the first idle cycle,
    // so the next grant is another full starvation interval away.
    run_burst(1'b0, 32'h300, 4'd1, 1'b1, SL - 1, 1'b0, "starve_2");
    idle_inputs();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
    run_burst(1'b1, 32'hFFFF_FFF8, 4'd3, 1'b0, 1, 1'b0, "wrap_wr");
    run_burst(1'b0, 32'hFFFF_FFF8, 4'd3, 1'b0, 1, 1'b0, "wrap_rd");
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    logic [31:0] base;
    logic [31:0] a;
    base = 32'h180;
    for (int i = 0; i < 4; i++) wbeat[i] = $urandom;
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = base; ext_len = 4'd3;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ext_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_gnt got %b expected 1", ext_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ext_req = 1'b0; ext_wdata = wbeat[i];
      #1;
      n_cmp++;
      if (ext_wready !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_beat %0d wready=%b expected 1", i, ext_wready);
      end
      if (i < 2) begin
        a = base + 32'(4 * i);
        ref_mem[a[9:2]] = wbeat[i];
      end
    end
    // Beat 2 is on the bus; drop reset before its write edge.
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ext_gnt, ext_wready, ext_rvalid, ext_done, core_stall, mem_write} !== 6'b0 || ext_rdata !== '0) begin
      n_bad++;
      $display("FAIL abort_async gnt=%b wready=%b rvalid=%b done=%b stall=%b wr=%b rdata=%h expected all 0",
               ext_gnt, ext_wready, ext_rvalid, ext_done, core_stall, mem_write, ext_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ext_done !== 1'b0 || ext_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done cycle %0d done=%b gnt=%b expected 0/0", c, ext_done, ext_gnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = base + 32'(4 * i);
      core_read = 1'b1; core_addr = a;
      #1;
      n_cmp++;
      if (core_rdata !== ref_mem[a[9:2]]) begin
        n_bad++;
        $display("FAIL abort_readback addr=%h got %h expected %h", a, core_rdata, ref_mem[a[9:2]]);
      end
    end
    $display("reset abort mid-burst at beat 2, base=%h", base);
    idle_inputs();
  endtask

  task automatic test_random_bursts();
    logic        we;
    logic        busy;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] a;
    int          k;
    for (int t = 0; t < 12; t++) begin
      we   = 1'($urandom_range(0, 1));
      busy = 1'($urandom_range(0, 1));
      addr = $urandom & 32'hFFFF_FFFC;
      len  = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) wbeat[i] = $urandom;
      run_burst(we, addr, len, busy, busy ? SL : 1, 1'b0, $sformatf("rand%0d", t));
      k = $urandom_range(0, int'(len));
      @(negedge clk);
      core_read = 1'b1; core_addr = addr + 32'(4 * k);
      a = core_addr;
      #1;
      n_cmp++;
      if (core_rdata !== ref_mem[a[9:2]]) begin
        n_bad++;
        $display("FAIL rand_readback addr=%h got %h expected %h", a, core_rdata, ref_mem[a[9:2]]);
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_write_then_core_read();
    test_read_burst();
    test_starvation();
    test_wrap();
    test_reset_abort();
    test_random_bursts();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
